// File: rtl/des_sbox_seq.sv
// des_sbox_seq: DES S-box sequencer issuing eight 6-bit chunks through one shared lookup port.
// Define DES_SBOX_SEQ_REG_EN to register sb_sel/sb_in; bit n-1 of each vector is DES bit 1.
module des_sbox_seq #(
  parameter bit ORDER = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  sb_sel,
  output logic [5:0]  sb_in,
  input  logic [3:0]  sb_out,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [2:0] cnt, cap_idx, last;
  logic [47:0] data_q, shd;
  logic [31:0] res, res_n;
  logic cap;
  assign last = {3{~ORDER}};
`ifdef DES_SBOX_SEQ_REG_EN
  logic [2:0] icnt, ix, sel_d;
  logic iss, iss_d, issue;
  // the first chunk is addressed straight from in_data on the accept edge
  assign icnt = state == IDLE ? 3'd0 : cnt;
  assign ix = ORDER ? ~icnt : icnt;
  assign shd = (state == IDLE ? in_data : data_q) << (6 * ix);
  assign issue = state == IDLE ? in_valid : state == RUN && iss && cnt != 3'd0;
  assign cap = state == RUN && iss_d;
  assign cap_idx = sel_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_sel <= 3'd0;
      sb_in <= 6'd0;
      iss <= 1'b0;
      iss_d <= 1'b0;
      sel_d <= 3'd0;
      cnt <= 3'd0;
    end else begin
      sb_sel <= issue ? ix : 3'd0;
      sb_in <= issue ? shd[47:42] : 6'd0;
      iss <= issue;
      iss_d <= iss;
      sel_d <= sb_sel;
      if (issue) cnt <= icnt + 3'd1;
    end
  end
`else
  logic [2:0] idx;
  assign idx = ORDER ? ~cnt : cnt;
  assign shd = data_q << (6 * idx);
  assign sb_sel = state == RUN ? idx : 3'd0;
  assign sb_in = state == RUN ? shd[47:42] : 6'd0;
  assign cap = state == RUN;
  assign cap_idx = idx;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= 3'd0;
    else cnt <= state == RUN ? cnt + 3'd1 : 3'd0;
  end
`endif
  always_comb begin
    res_n = res;
    for (int k = 0; k < 8; k++)
      if (cap && cap_idx == 3'(k)) res_n[31-4*k -: 4] = sb_out;
  end
  always_comb
    nxt = state == IDLE ? (in_valid ? RUN : IDLE)
        : state == RUN ? (cap && cap_idx == last ? DONE : RUN)
        : (out_ready ? IDLE : DONE);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
      data_q <= '0;
      res <= '0;
      out_data <= '0;
    end else begin
      state <= nxt;
      in_ready <= nxt == IDLE;
      out_valid <= nxt == DONE;
      busy <= nxt != IDLE;
      res <= res_n;
      if (state == IDLE && in_valid) data_q <= in_data;
      if (state == RUN && nxt == DONE) out_data <= res_n;
    end
  end
endmodule
